// File: rtl/nbody_seq.sv
// nbody_seq: control and sequencing core of the N-body accelerator.
//
// Decodes the host bus (command = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH], body index = low bits)
// into per-array RAM write strobes and status/position readback. It also runs the step loop:
// ACCEL issues (i, j-group) pairs to LANES getAccl pipelines, DRAIN_A waits ACC_LAT cycles,
// POS issues one position update per body, and DRAIN_P waits UPD_LAT cycles. This repeats
// STEPS times, then the core parks in DONE until software acks.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   chipselect_i, write_i, read_i    host bus strobes
//   addr_i, write_data_i             host bus address / write data
//   read_data_o                      host read data, valid the cycle after read_i
//   mem_wdata_o, mem_waddr_o         RAM write data / body index (pass-through)
//   mem_wren_o                       one-hot {vy,vx,m,y,x} software write strobes
//   mem_rdaddr_o, mem_rsel_o         RAM readback index / select (0=x, 1=y)
//   mem_rdata_i                      RAM readback data, 1-cycle latency
//   pair_*_o                         pair issue to the acceleration lanes
//   upd_valid_o, upd_idx_o           position update issue
//   busy_o, done_o                   run status
//
// Build option: define NBODY_PERF_CNT_EN to add a 64-bit busy-cycle counter at command 0x43.
// ACC_LAT and UPD_LAT must be at least 1.
module nbody_seq #(
  parameter int unsigned BODIES          = 512,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int unsigned LANES           = 1,
  parameter int unsigned ACC_LAT         = 60,
  parameter int unsigned UPD_LAT         = 20
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             chipselect_i,
  input  logic                             write_i,
  input  logic                             read_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            write_data_i,
  output logic [DATA_WIDTH-1:0]            read_data_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [BODY_ADDR_WIDTH-1:0]       mem_waddr_o,
  output logic [4:0]                       mem_wren_o,
  output logic [BODY_ADDR_WIDTH-1:0]       mem_rdaddr_o,
  output logic                             mem_rsel_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             pair_valid_o,
  output logic [BODY_ADDR_WIDTH-1:0]       pair_i_o,
  output logic [LANES*BODY_ADDR_WIDTH-1:0] pair_j_o,
  output logic [LANES-1:0]                 pair_lane_en_o,
  output logic                             pair_first_o,
  output logic                             pair_last_o,
  output logic                             upd_valid_o,
  output logic [BODY_ADDR_WIDTH-1:0]       upd_idx_o,
  output logic                             busy_o,
  output logic                             done_o
);
  localparam int unsigned BW = BODY_ADDR_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH - BODY_ADDR_WIDTH;
  localparam int unsigned NW = BW + 1;  // holds 1..BODIES
  localparam int unsigned XW = BW + 2;  // headroom for base+LANES

  localparam logic [CW-1:0] CmdCtrl   = CW'(0);
  localparam logic [CW-1:0] CmdAck    = CW'(1);
  localparam logic [CW-1:0] CmdNBod   = CW'(2);
  localparam logic [CW-1:0] CmdSteps  = CW'(3);
  localparam logic [CW-1:0] CmdWrX    = CW'(4);
  localparam logic [CW-1:0] CmdWrY    = CW'(5);
  localparam logic [CW-1:0] CmdWrM    = CW'(6);
  localparam logic [CW-1:0] CmdWrVx   = CW'(7);
  localparam logic [CW-1:0] CmdWrVy   = CW'(8);
  localparam logic [CW-1:0] CmdStatus = CW'(8'h40);
  localparam logic [CW-1:0] CmdRdX    = CW'(8'h41);
  localparam logic [CW-1:0] CmdRdY    = CW'(8'h42);
`ifdef NBODY_PERF_CNT_EN
  localparam logic [CW-1:0] CmdPerf   = CW'(8'h43);
`endif

  typedef enum logic [2:0] {StIdle, StAccel, StDrainA, StPos, StDrainP, StDone} state_e;

  state_e          state_q;
  logic            go_q;
  logic [NW-1:0]   n_q;
  logic [31:0]     steps_q;
  logic [31:0]     step_cnt_q;
  logic [BW-1:0]   i_q;
  logic [XW-1:0]   base_q;
  logic [15:0]     lat_q;
  logic [BW-1:0]   upd_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic            rd_mem_q;
`ifdef NBODY_PERF_CNT_EN
  logic [63:0]     perf_q;
`endif

  logic [CW-1:0] cmd;
  logic          wr, rd, idle_or_done, last_grp, last_i, abort;
  logic [XW-1:0] n_x;
  logic [NW-1:0] n_wr;
  logic [31:0]   steps_wr;
  logic [63:0]   rd_word;

  assign cmd          = addr_i[ADDR_WIDTH-1:BW];
  assign wr           = chipselect_i & write_i;
  assign rd           = chipselect_i & read_i;
  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign busy_o       = !idle_or_done;
  assign done_o       = (state_q == StDone);
  assign n_x          = XW'(n_q);
  assign last_grp     = (base_q + XW'(LANES)) >= n_x;
  assign last_i       = (XW'(i_q) + XW'(1)) == n_x;
  assign abort        = wr && (cmd == CmdCtrl) && !write_data_i[0] && (state_q != StIdle);
  assign n_wr         = write_data_i[NW-1:0];
  assign steps_wr     = (write_data_i[31:0] == 32'd0) ? 32'd1 : write_data_i[31:0];

  assign mem_wdata_o  = write_data_i;
  assign mem_waddr_o  = addr_i[BW-1:0];
  assign mem_rdaddr_o = addr_i[BW-1:0];
  assign mem_rsel_o   = (cmd == CmdRdY);
  assign read_data_o  = rd_mem_q ? mem_rdata_i : read_data_q;

  // Array writes are only safe while the datapath is not reading the RAMs.
  always_comb begin
    mem_wren_o = 5'b00000;
    if (wr && idle_or_done) begin
      case (cmd)
        CmdWrX:  mem_wren_o = 5'b00001;
        CmdWrY:  mem_wren_o = 5'b00010;
        CmdWrM:  mem_wren_o = 5'b00100;
        CmdWrVx: mem_wren_o = 5'b01000;
        CmdWrVy: mem_wren_o = 5'b10000;
        default: mem_wren_o = 5'b00000;
      endcase
    end
  end

  always_comb begin
    rd_word = 64'd0;
    case (cmd)
      CmdStatus: rd_word = {step_cnt_q, 29'd0, go_q, busy_o, done_o};
`ifdef NBODY_PERF_CNT_EN
      CmdPerf:   rd_word = perf_q;
`endif
      default:   rd_word = 64'd0;
    endcase
  end

  // Pair issue decoded from the loop registers; lane k sources body base+k.
  always_comb begin
    pair_valid_o   = (state_q == StAccel);
    pair_i_o       = i_q;
    pair_first_o   = pair_valid_o && (base_q == XW'(0));
    pair_last_o    = pair_valid_o && last_grp;
    pair_j_o       = '0;
    pair_lane_en_o = '0;
    for (int k = 0; k < LANES; k++) begin
      pair_j_o[k*BW +: BW] = BW'(base_q + XW'(k));
      pair_lane_en_o[k]    = pair_valid_o && ((base_q + XW'(k)) < n_x) &&
                             ((base_q + XW'(k)) != XW'(i_q));
    end
    upd_valid_o = (state_q == StPos);
    upd_idx_o   = upd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      go_q        <= 1'b0;
      n_q         <= NW'(1);
      steps_q     <= 32'd1;
      step_cnt_q  <= 32'd0;
      i_q         <= '0;
      base_q      <= '0;
      lat_q       <= '0;
      upd_q       <= '0;
      read_data_q <= '0;
      rd_mem_q    <= 1'b0;
`ifdef NBODY_PERF_CNT_EN
      perf_q      <= 64'd0;
`endif
    end else begin
      if (wr && !busy_o) begin
        if (cmd == CmdNBod && n_wr != NW'(0) && XW'(n_wr) <= XW'(BODIES)) n_q <= n_wr;
        if (cmd == CmdSteps) steps_q <= steps_wr;
      end
      if (wr && cmd == CmdCtrl) go_q <= write_data_i[0];

      rd_mem_q <= rd && (cmd == CmdRdX || cmd == CmdRdY);
      if (rd) read_data_q <= DATA_WIDTH'(rd_word);

`ifdef NBODY_PERF_CNT_EN
      if (state_q == StIdle && go_q) perf_q <= 64'd0;
      else if (busy_o) perf_q <= perf_q + 64'd1;
`endif

      if (abort) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (go_q) begin
              state_q    <= StAccel;
              step_cnt_q <= 32'd0;
              i_q        <= '0;
              base_q     <= '0;
            end
          end
          StAccel: begin
            if (last_grp) begin
              base_q <= '0;
              if (last_i) begin
                state_q <= StDrainA;
                lat_q   <= '0;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              base_q <= base_q + XW'(LANES);
            end
          end
          StDrainA: begin
            if (lat_q == 16'(ACC_LAT - 1)) begin
              state_q <= StPos;
              upd_q   <= '0;
            end else begin
              lat_q <= lat_q + 16'd1;
            end
          end
          StPos: begin
            if ((XW'(upd_q) + XW'(1)) == n_x) begin
              state_q <= StDrainP;
              lat_q   <= '0;
            end else begin
              upd_q <= upd_q + 1'b1;
            end
          end
          StDrainP: begin
            if (lat_q == 16'(UPD_LAT - 1)) begin
              step_cnt_q <= step_cnt_q + 32'd1;
              if (step_cnt_q + 32'd1 == steps_q) begin
                state_q <= StDone;
              end else begin
                state_q <= StAccel;
                i_q     <= '0;
                base_q  <= '0;
              end
            end else begin
              lat_q <= lat_q + 16'd1;
            end
          end
          StDone: begin
            // Ack consumes go so the core does not relaunch from IDLE.
            if (wr && cmd == CmdAck) begin
              state_q <= StIdle;
              go_q    <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nbody_seq.sv
module tb_nbody_seq;
  localparam int unsigned Bodies = 16;
  localparam int unsigned Lanes  = 2;
  localparam int unsigned AccLat = 6;
  localparam int unsigned UpdLat = 4;
  localparam int unsigned Dw     = 64;
  localparam int unsigned Aw     = 16;
  localparam int unsigned Bw     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [Aw-1:0]     addr = '0;
  logic [Dw-1:0]     write_data = '0;
  logic [Dw-1:0]     read_data, mem_wdata, mem_rdata;
  logic [Bw-1:0]     mem_waddr, mem_rdaddr, pair_i, upd_idx;
  logic [4:0]        mem_wren;
  logic              mem_rsel, pair_valid, pair_first, pair_last, upd_valid, busy, done;
  logic [Lanes*Bw-1:0] pair_j;
  logic [Lanes-1:0]  pair_lane_en;

  nbody_seq #(
    .BODIES(Bodies), .DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .BODY_ADDR_WIDTH(Bw),
    .LANES(Lanes), .ACC_LAT(AccLat), .UPD_LAT(UpdLat)
  ) dut (
    .clk_i(clk), .rst_i(rst), .chipselect_i(chipselect), .write_i(write), .read_i(read),
    .addr_i(addr), .write_data_i(write_data), .read_data_o(read_data),
    .mem_wdata_o(mem_wdata), .mem_waddr_o(mem_waddr), .mem_wren_o(mem_wren),
    .mem_rdaddr_o(mem_rdaddr), .mem_rsel_o(mem_rsel), .mem_rdata_i(mem_rdata),
    .pair_valid_o(pair_valid), .pair_i_o(pair_i), .pair_j_o(pair_j),
    .pair_lane_en_o(pair_lane_en), .pair_first_o(pair_first), .pair_last_o(pair_last),
    .upd_valid_o(upd_valid), .upd_idx_o(upd_idx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ram_word(input logic [Bw-1:0] a, input logic s);
    return 64'hC0DE_0000_0000_0000 | (64'(s) << 8) | 64'(a);
  endfunction

  // RAM model with 1-cycle read latency
  always @(posedge clk) mem_rdata <= ram_word(mem_rdaddr, mem_rsel);

  function automatic logic [63:0] status_word(input int steps, input bit g, input bit b,
                                              input bit d);
    return {32'(steps), 29'd0, g, b, d};
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [4:0]    wren_seen;
  logic [Bw-1:0] waddr_seen;
  logic [Dw-1:0] wdata_seen;

  task automatic bus_write(input int cmd, input int idx, input logic [63:0] data);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; addr = Aw'((cmd << Bw) | idx); write_data = data;
    #1;
    wren_seen = mem_wren; waddr_seen = mem_waddr; wdata_seen = mem_wdata;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int cmd, input int idx, output logic [63:0] data,
                          output logic sel, output logic [Bw-1:0] ra);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; addr = Aw'((cmd << Bw) | idx);
    #1;
    sel = mem_rsel; ra = mem_rdaddr;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    data = read_data;
  endtask

  typedef struct {int i; int base;} pair_t;

  // Launches a run and checks every pair/update against the nested-loop schedule.
  task automatic run_check(input int n, input int steps, input string tag);
    pair_t pq[$];
    int    uq[$];
    int    per_step, t_exp, cyc;
    bit    finished;
    logic [63:0] d;
    logic s;
    logic [Bw-1:0] ra;
    per_step = 0;
    for (int st = 0; st < steps; st++) begin
      for (int i = 0; i < n; i++)
        for (int b = 0; b < n; b += Lanes) begin
          pq.push_back('{i: i, base: b});
          if (st == 0) per_step++;
        end
      for (int u = 0; u < n; u++) uq.push_back(u);
    end
    t_exp = steps * (per_step + AccLat + n + UpdLat) + 1;
    bus_write(0, 0, 64'd1);
    cyc = 0;
    finished = 0;
    while (!finished && cyc < t_exp + 40) begin
      @(negedge clk);
      cyc++;
      if (pair_valid) begin
        if (pq.size() == 0) check_val($sformatf("%s_extra_pair", tag), 1, 0);
        else begin
          pair_t e;
          logic [Lanes-1:0] en;
          logic [Lanes*Bw-1:0] jexp, jmask;
          e = pq.pop_front();
          en = '0; jexp = '0; jmask = '0;
          for (int k = 0; k < Lanes; k++) begin
            en[k] = (e.base + k < n) && (e.base + k != e.i);
            if (en[k]) begin
              jexp[k*Bw +: Bw]  = Bw'(e.base + k);
              jmask[k*Bw +: Bw] = '1;
            end
          end
          check_val($sformatf("%s_pair_i", tag), 64'(pair_i), 64'(e.i));
          check_val($sformatf("%s_lane_en", tag), 64'(pair_lane_en), 64'(en));
          check_val($sformatf("%s_pair_j", tag), 64'(pair_j & jmask), 64'(jexp));
          check_val($sformatf("%s_first", tag), 64'(pair_first), 64'(e.base == 0));
          check_val($sformatf("%s_last", tag), 64'(pair_last), 64'(e.base + Lanes >= n));
        end
      end
      if (upd_valid) begin
        if (uq.size() == 0) check_val($sformatf("%s_extra_upd", tag), 1, 0);
        else check_val($sformatf("%s_upd_idx", tag), 64'(upd_idx), 64'(uq.pop_front()));
      end
      if (done) finished = 1;
    end
    check_val($sformatf("%s_done_cycle", tag), 64'(cyc), 64'(t_exp));
    check_val($sformatf("%s_pairs_left", tag), 64'(pq.size()), 0);
    check_val($sformatf("%s_upds_left", tag), 64'(uq.size()), 0);
    bus_read(8'h40, 0, d, s, ra);
    check_val($sformatf("%s_status_done", tag), d, status_word(steps, 1, 0, 1));
    bus_write(1, 0, 64'd0);
    bus_read(8'h40, 0, d, s, ra);
    check_val($sformatf("%s_status_acked", tag), d, status_word(steps, 0, 0, 0));
  endtask

  initial begin
    logic [63:0] d, wd;
    logic s;
    logic [Bw-1:0] ra;
    int cnt, bound;
    #1;
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_done", 64'(done), 0);
    check_val("rst_pair_valid", 64'(pair_valid), 0);
    check_val("rst_read_data", read_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Default N=1, STEPS=1: one fully masked group per step.
    run_check(1, 1, "n1_default");

    bus_write(2, 0, 64'd5);
    run_check(5, 1, "n5_s1");
    bus_write(3, 0, 64'd3);
    run_check(5, 3, "n5_s3");

    wd = {$urandom, $urandom};
    bus_write(4, 7, wd);
    check_val("wr_x_wren", 64'(wren_seen), 64'(5'b00001));
    check_val("wr_x_waddr", 64'(waddr_seen), 7);
    check_val("wr_x_wdata", wdata_seen, wd);
    bus_write(8, 2, wd);
    check_val("wr_vy_wren", 64'(wren_seen), 64'(5'b10000));
    bus_write(9, 2, wd);
    check_val("wr_unknown_wren", 64'(wren_seen), 0);
    bus_read(8'h42, 3, d, s, ra);
    check_val("rd_y_sel", 64'(s), 1);
    check_val("rd_y_addr", 64'(ra), 3);
    check_val("rd_y_data", d, ram_word(4'd3, 1'b1));
    bus_read(8'h41, 9, d, s, ra);
    check_val("rd_x_sel", 64'(s), 0);
    check_val("rd_x_data", d, ram_word(4'd9, 1'b0));
    bus_read(8'h43, 0, d, s, ra);
    check_val("rd_perf_absent", d, 0);
    bus_read(8'h7f, 0, d, s, ra);
    check_val("rd_unknown", d, 0);

    // Illegal N values are dropped; STEPS=0 acts as 1.
    bus_write(2, 0, 64'd0);
    bus_write(2, 0, 64'd17);
    bus_write(3, 0, 64'd0);
    run_check(5, 1, "illegal_n");
    bus_write(2, 0, 64'd16);
    run_check(16, 1, "n_max");

    // Writes while busy are dropped, then abort.
    bus_write(2, 0, 64'd5);
    bus_write(0, 0, 64'd1);
    bus_write(6, 2, wd);
    check_val("busy_wr_m_wren", 64'(wren_seen), 0);
    bus_write(2, 0, 64'd3);
    bus_write(3, 0, 64'd2);
    bus_write(0, 0, 64'd0);
    check_val("abort_busy", 64'(busy), 0);
    run_check(5, 1, "kept_n");

    // Abort during the second POS phase, then restart.
    bus_write(3, 0, 64'd2);
    bus_write(0, 0, 64'd1);
    cnt = 0; bound = 0;
    while (cnt < 6 && bound < 500) begin
      @(negedge clk);
      bound++;
      if (upd_valid) cnt++;
    end
    check_val("abort_reached_pos", 64'(cnt), 6);
    bus_write(0, 0, 64'd0);
    check_val("abort_upd_valid", 64'(upd_valid), 0);
    check_val("abort_busy2", 64'(busy), 0);
    check_val("abort_done", 64'(done), 0);
    bus_read(8'h40, 0, d, s, ra);
    check_val("abort_status", d, status_word(1, 0, 0, 0));
    run_check(5, 2, "restart");

    // Asynchronous reset mid-ACCEL.
    bus_write(3, 0, 64'd1);
    bus_write(0, 0, 64'd1);
    @(negedge clk); @(negedge clk);
    check_val("pre_rst_pair_valid", 64'(pair_valid), 1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 64'(busy), 0);
    check_val("mid_rst_done", 64'(done), 0);
    check_val("mid_rst_pair_valid", 64'(pair_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(8'h40, 0, d, s, ra);
    check_val("mid_rst_status", d, 0);
    run_check(1, 1, "post_rst_n1");

    for (int r = 0; r < 4; r++) begin
      int n, st;
      n  = $urandom_range(1, Bodies);
      st = $urandom_range(0, 3);
      bus_write(2, 0, 64'(n));
      bus_write(3, 0, 64'(st));
      run_check(n, (st == 0) ? 1 : st, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
